silent_lpf_v3: RTL and testbench

SILENT_LPF_V3 -- requirements
Module: silent_lpf_v3

---
 rtl/silent_lpf_pkg.sv | 37 +++
 rtl/silent_lpf_step.sv | 82 ++++++++
 rtl/silent_lpf_v3.sv | 187 ++++++++++++++++++
 tb/tb_silent_lpf_v3.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silent_lpf_pkg.sv
// silent_lpf_pkg -- shared definitions for the silent_lpf_v3 step-limited filter.
//   lpf_state_e  : sweep controller states (IDLE -> SWEEP -> FLUSH -> IDLE)
//   DIFF_EXTRA   : signed differences are one bit wider than the data width
//   diff_width() : width of a signed target-minus-current difference
//   clamp_step() : limits a signed difference to +/- step
package silent_lpf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FLUSH = 2'd2
  } lpf_state_e;

  // Signed difference width is WIDTH + DIFF_EXTRA, i.e. WIDTH+1.
  localparam int DIFF_EXTRA = 1;

  // Arithmetic width used around the clamp; wide enough for WIDTH up to 30.
  localparam int CALC_W = 32;

  function automatic int diff_width(input int w);
    return w + DIFF_EXTRA;
  endfunction

  // Pass d through when |d| <= step, otherwise move exactly step toward it.
  function automatic logic signed [CALC_W-1:0] clamp_step(
    input logic signed [CALC_W-1:0] d,
    input logic signed [CALC_W-1:0] step
  );
    if (d > step) begin
      return step;
    end else if (d < -step) begin
      return -step;
    end
    return d;
  endfunction

endpackage

// File: rtl/silent_lpf_step.sv
// silent_lpf_step -- combinational per-channel duty/phase update.
// One instance is shared by all channels (time-multiplexed by the sweep).
//   en         : 1 = step-limited, 0 = jump straight to the targets
//   step_duty  : max duty change this sweep
//   step_phase : max phase change this sweep
//   cycle      : channel period in PWM ticks
//   duty_tgt   : raw duty target (clamped to cycle here)
//   phase_tgt  : raw phase target (folded into one period here)
//   duty_cur   : current filtered duty
//   phase_cur  : current filtered phase
//   duty_nxt   : next filtered duty
//   phase_nxt  : next filtered phase, always in [0, cycle-1] for sane inputs
module silent_lpf_step
  import silent_lpf_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             en,
  input  logic [WIDTH-1:0] step_duty,
  input  logic [WIDTH-1:0] step_phase,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] duty_tgt,
  input  logic [WIDTH-1:0] phase_tgt,
  input  logic [WIDTH-1:0] duty_cur,
  input  logic [WIDTH-1:0] phase_cur,
  output logic [WIDTH-1:0] duty_nxt,
  output logic [WIDTH-1:0] phase_nxt
);

  localparam int DW = diff_width(WIDTH);

  logic [WIDTH-1:0]         td;
  logic [WIDTH-1:0]         tp;
  logic signed [DW-1:0]     d_duty;
  logic signed [DW-1:0]     d_phase;
  logic signed [CALC_W-1:0] cyc_w;
  logic signed [CALC_W-1:0] half_w;
  logic signed [CALC_W-1:0] dd_w;
  logic signed [CALC_W-1:0] dp_w;
  logic signed [CALC_W-1:0] dp_adj;
  logic signed [CALC_W-1:0] mv_duty;
  logic signed [CALC_W-1:0] mv_phase;
  logic signed [CALC_W-1:0] sum_phase;

  always_comb begin
    td        = (duty_tgt < cycle) ? duty_tgt : cycle;
    tp        = (phase_tgt < cycle) ? phase_tgt : (phase_tgt - cycle);
    d_duty    = $signed({1'b0, td}) - $signed({1'b0, duty_cur});
    d_phase   = $signed({1'b0, tp}) - $signed({1'b0, phase_cur});
    cyc_w     = {{(CALC_W-WIDTH){1'b0}}, cycle};
    half_w    = cyc_w >>> 1;
    dd_w      = {{(CALC_W-DW){d_duty[DW-1]}}, d_duty};
    dp_w      = {{(CALC_W-DW){d_phase[DW-1]}}, d_phase};

    // Shortest way round the circle; d == +half keeps the positive direction.
    dp_adj = dp_w;
    if (dp_w > half_w) begin
      dp_adj = dp_w - cyc_w;
    end else if (dp_w < -half_w) begin
      dp_adj = dp_w + cyc_w;
    end

    mv_duty   = clamp_step(dd_w, {{(CALC_W-WIDTH){1'b0}}, step_duty});
    mv_phase  = clamp_step(dp_adj, {{(CALC_W-WIDTH){1'b0}}, step_phase});
    sum_phase = {{(CALC_W-WIDTH){1'b0}}, phase_cur} + mv_phase;

    duty_nxt  = td;
    phase_nxt = tp;
    if (en) begin
      // Duty moves toward td, so it never leaves [0, 2^WIDTH-1].
      duty_nxt = WIDTH'({{(CALC_W-WIDTH){1'b0}}, duty_cur} + mv_duty);
      if (sum_phase < 0) begin
        phase_nxt = WIDTH'(sum_phase + cyc_w);
      end else if (sum_phase >= cyc_w) begin
        phase_nxt = WIDTH'(sum_phase - cyc_w);
      end else begin
        phase_nxt = WIDTH'(sum_phase);
      end
    end
  end

endmodule

// File: rtl/silent_lpf_v3.sv
// silent_lpf_v3 -- step-limited duty/phase filter for DEPTH transducer channels.
// A START rising edge launches one sweep that visits channels 0..DEPTH-1, one
// per cycle, through a 2-stage pipeline (read inputs, then compute + write).
// Ports:
//   CLK, RST_N              : clock, asynchronous active-low reset
//   ENABLE                  : 1 = step-limited, 0 = bypass (captured at START)
//   START                   : sweep strobe, only its rising edge counts
//   STEP_DUTY, STEP_PHASE   : per-sweep step limits (captured at START)
//   CYCLE, DUTY, PHASE      : per-channel period and targets, read live
//   DUTY_S, PHASE_S         : filtered registered outputs
//   BUSY                    : high while the sweep pipeline is active
//   DONE                    : one-cycle pulse when a sweep has completed
//   dbg_state               : current controller state (lpf_state_e encoding)
// Handshake: START is a level strobe; a rising edge is accepted only in IDLE
// with DONE low; anything else is dropped, never queued.
module silent_lpf_v3
  import silent_lpf_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             START,
  input  logic [WIDTH-1:0] STEP_DUTY,
  input  logic [WIDTH-1:0] STEP_PHASE,
  input  logic [WIDTH-1:0] CYCLE   [0:DEPTH-1],
  input  logic [WIDTH-1:0] DUTY    [0:DEPTH-1],
  input  logic [WIDTH-1:0] PHASE   [0:DEPTH-1],
  output logic [WIDTH-1:0] DUTY_S  [0:DEPTH-1],
  output logic [WIDTH-1:0] PHASE_S [0:DEPTH-1],
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lpf_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_q;
  logic             arm_q, arm_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic             s1_v_q, s1_v_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [WIDTH-1:0] s1_cyc_q, s1_cyc_d;
  logic [WIDTH-1:0] s1_duty_q, s1_duty_d;
  logic [WIDTH-1:0] s1_phase_q, s1_phase_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] duty_s_q  [0:DEPTH-1];
  logic [WIDTH-1:0] duty_s_d  [0:DEPTH-1];
  logic [WIDTH-1:0] phase_s_q [0:DEPTH-1];
  logic [WIDTH-1:0] phase_s_d [0:DEPTH-1];
  logic             start_rise;
  logic [WIDTH-1:0] duty_nxt;
  logic [WIDTH-1:0] phase_nxt;

  // arm_q stays low until START has been seen low after reset, so a START
  // that is already high when reset releases never counts as an edge.
  assign start_rise = START & ~start_q & arm_q;

  silent_lpf_step #(.WIDTH(WIDTH)) u_step (
    .en        (en_q),
    .step_duty (sd_q),
    .step_phase(sp_q),
    .cycle     (s1_cyc_q),
    .duty_tgt  (s1_duty_q),
    .phase_tgt (s1_phase_q),
    .duty_cur  (duty_s_q[s1_idx_q]),
    .phase_cur (phase_s_q[s1_idx_q]),
    .duty_nxt  (duty_nxt),
    .phase_nxt (phase_nxt)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    arm_d      = arm_q | ~START;
    en_d       = en_q;
    sd_d       = sd_q;
    sp_d       = sp_q;
    s1_v_d     = 1'b0;
    s1_idx_d   = s1_idx_q;
    s1_cyc_d   = s1_cyc_q;
    s1_duty_d  = s1_duty_q;
    s1_phase_d = s1_phase_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise && !done_q) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          en_d    = ENABLE;
          sd_d    = STEP_DUTY;
          sp_d    = STEP_PHASE;
        end
      end
      ST_SWEEP: begin
        // Stage 1: latch channel idx inputs for the compute/write stage.
        s1_v_d     = 1'b1;
        s1_idx_d   = idx_q;
        s1_cyc_d   = CYCLE[idx_q];
        s1_duty_d  = DUTY[idx_q];
        s1_phase_d = PHASE[idx_q];
        busy_d     = 1'b1;
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        // One cycle to write the last channel, then report completion.
        if (s1_v_q) begin
          busy_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    duty_s_d  = duty_s_q;
    phase_s_d = phase_s_q;
    if (s1_v_q) begin
      duty_s_d[s1_idx_q]  = duty_nxt;
      phase_s_d[s1_idx_q] = phase_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      start_q    <= 1'b0;
      arm_q      <= 1'b0;
      en_q       <= 1'b0;
      sd_q       <= '0;
      sp_q       <= '0;
      s1_v_q     <= 1'b0;
      s1_idx_q   <= '0;
      s1_cyc_q   <= '0;
      s1_duty_q  <= '0;
      s1_phase_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        duty_s_q[i]  <= '0;
        phase_s_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      start_q    <= START;
      arm_q      <= arm_d;
      en_q       <= en_d;
      sd_q       <= sd_d;
      sp_q       <= sp_d;
      s1_v_q     <= s1_v_d;
      s1_idx_q   <= s1_idx_d;
      s1_cyc_q   <= s1_cyc_d;
      s1_duty_q  <= s1_duty_d;
      s1_phase_q <= s1_phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      duty_s_q   <= duty_s_d;
      phase_s_q  <= phase_s_d;
    end
  end

  assign DUTY_S    = duty_s_q;
  assign PHASE_S   = phase_s_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_silent_lpf_v3.sv
// tb_silent_lpf_v3 -- scoreboard bench for silent_lpf_v3 (WIDTH=13, DEPTH=249).
// Each sweep request pushes the expected {duty, phase} of every channel into
// exp_q; the monitor pops and compares all channels whenever DONE pulses.
module tb_silent_lpf_v3;

  localparam int W = 13;
  localparam int D = 249;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         start;
  logic [W-1:0] step_duty;
  logic [W-1:0] step_phase;
  logic [W-1:0] cycle   [0:D-1];
  logic [W-1:0] duty    [0:D-1];
  logic [W-1:0] phase   [0:D-1];
  logic [W-1:0] duty_s  [0:D-1];
  logic [W-1:0] phase_s [0:D-1];
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  int mdl_d [D];
  int mdl_p [D];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  silent_lpf_v3 #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .ENABLE    (enable),
    .START     (start),
    .STEP_DUTY (step_duty),
    .STEP_PHASE(step_phase),
    .CYCLE     (cycle),
    .DUTY      (duty),
    .PHASE     (phase),
    .DUTY_S    (duty_s),
    .PHASE_S   (phase_s),
    .BUSY      (busy),
    .DONE      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int move_toward(input int cur, input int tgt, input int step);
    if (tgt - cur > step) return cur + step;
    if (cur - tgt > step) return cur - step;
    return tgt;
  endfunction

  // Reference behaviour for one channel, written from the filter's definition.
  task automatic model_channel(input int i, input bit en, input int sd, input int sp);
    int c, td, tp, diff, np;
    c  = int'(cycle[i]);
    td = (int'(duty[i]) < c) ? int'(duty[i]) : c;
    tp = (int'(phase[i]) < c) ? int'(phase[i]) : int'(phase[i]) - c;
    if (!en) begin
      mdl_d[i] = td;
      mdl_p[i] = tp;
    end else begin
      mdl_d[i] = move_toward(mdl_d[i], td, sd);
      diff = tp - mdl_p[i];
      if (diff > c / 2) diff -= c;
      else if (diff < -(c / 2)) diff += c;
      np = move_toward(mdl_p[i], mdl_p[i] + diff, sp);
      if (np < 0) np += c;
      else if (np >= c) np -= c;
      mdl_p[i] = np;
    end
  endtask

  task automatic push_expected(input bit en, input int sd, input int sp);
    for (int i = 0; i < D; i++) begin
      model_channel(i, en, sd, sp);
      exp_q.push_back({W'(mdl_d[i]), W'(mdl_p[i])});
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      mdl_d[i] = 0;
      mdl_p[i] = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_sweep(input bit en, input int sd, input int sp);
    int n;
    enable     = en;
    step_duty  = W'(sd);
    step_phase = W'(sp);
    push_expected(en, sd, sp);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout: got no DONE after %0d cycles expected DONE", n);
    end
    @(negedge clk);
  endtask

  task automatic set_all(input int c, input int dv, input int pv);
    for (int i = 0; i < D; i++) begin
      cycle[i] = W'(c);
      duty[i]  = W'(dv);
      phase[i] = W'(pv);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        for (int i = 0; i < D; i++) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got DONE with channel %0d unexpected, expected no sweep", i);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("duty_s[%0d]", i), int'(duty_s[i]), int'(e[2*W-1:W]));
            check($sformatf("phase_s[%0d]", i), int'(phase_s[i]), int'(e[W-1:0]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int prev_d [D];
    int prev_p [D];
    int mx, dd, cnt;

    rst_n = 1'b0; start = 1'b0; enable = 1'b0;
    step_duty = '0; step_phase = '0;
    set_all(5000, 0, 0);
    model_clear();
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), 0);
    check("rst_duty0", int'(duty_s[0]), 0);
    check("rst_phase_last", int'(phase_s[D-1]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bypass plus cycle-exact timing; a second edge at k+100 must be dropped.
    set_all(5000, 4000, 5000);
    enable = 1'b0; step_duty = '0; step_phase = '0;
    push_expected(1'b0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);           // edge k
    #1;
    check("t_k_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 260; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        check("t_k1_busy", int'(busy), 1);
        check("t_k1_state", int'(dbg_state), 1);
        check("t_k1_duty0_old", int'(duty_s[0]), 0);
      end
      if (e == 2) begin
        check("t_k2_duty0", int'(duty_s[0]), 4000);
        check("t_k2_duty1_old", int'(duty_s[1]), 0);
      end
      if (e == D + 1) begin
        check("t_last_busy", int'(busy), 1);
        check("t_last_done", int'(done), 0);
        check("t_last_duty", int'(duty_s[D-1]), 4000);
      end
      if (e == D + 2) begin
        check("t_done_busy", int'(busy), 0);
        check("t_done_done", int'(done), 1);
        check("t_done_state", int'(dbg_state), 0);
      end
      if (e == D + 3) check("t_done_pulse", int'(done), 0);
      if (e == 260) check("t_no_queue_busy", int'(busy), 0);
      @(negedge clk);
      start = (e == 99);
    end
    check("bypass_phase0", int'(phase_s[0]), 0);

    // Reset then ramp toward directed per-channel targets.
    do_reset();
    for (int i = 0; i < D; i++) begin
      cycle[i] = W'(5000);
      duty[i]  = W'((i * 397 + 123) % 5000);
      phase[i] = W'((i * 2011 + 77) % 5000);
    end
    for (int s = 0; s < 55; s++) begin
      for (int i = 0; i < D; i++) begin
        prev_d[i] = int'(duty_s[i]);
        prev_p[i] = int'(phase_s[i]);
      end
      run_sweep(1'b1, 100, 100);
      mx = 0;
      for (int i = 0; i < D; i++) begin
        dd = int'(duty_s[i]) - prev_d[i];
        if (dd < 0) dd = -dd;
        if (dd > mx) mx = dd;
        dd = int'(phase_s[i]) - prev_p[i];
        if (dd < 0) dd = -dd;
        if (dd > 2500) dd = 5000 - dd;
        if (dd > mx) mx = dd;
      end
      total++;
      if (mx > 100) begin
        bad++;
        $display("FAIL ramp_step sweep %0d: got %0d max change expected <= 100", s, mx);
      end
    end
    for (int i = 0; i < D; i++) begin
      check($sformatf("ramp_duty[%0d]", i), int'(duty_s[i]), (i * 397 + 123) % 5000);
      check($sformatf("ramp_phase[%0d]", i), int'(phase_s[i]), (i * 2011 + 77) % 5000);
    end

    // Phase wrap: 4950 -> 0 (5000 wrapped) -> 30, crossing the period end.
    set_all(5000, 0, 4950);
    run_sweep(1'b0, 0, 0);
    check("wrap_init", int'(phase_s[0]), 4950);
    set_all(5000, 0, 30);
    run_sweep(1'b1, 0, 50);
    check("wrap_s1_ch0", int'(phase_s[0]), 0);
    check("wrap_s1_last", int'(phase_s[D-1]), 0);
    run_sweep(1'b1, 0, 50);
    check("wrap_s2_ch0", int'(phase_s[0]), 30);

    // Zero steps hold the outputs.
    set_all(5000, 1234, 2222);
    run_sweep(1'b1, 0, 0);
    check("hold_duty", int'(duty_s[5]), 0);
    check("hold_phase", int'(phase_s[5]), 30);

    // Duty target above the period is clamped to the period.
    set_all(5000, 6000, 30);
    run_sweep(1'b1, 8191, 0);
    check("clamp_duty0", int'(duty_s[0]), 5000);
    check("clamp_duty_last", int'(duty_s[D-1]), 5000);

    // Reset in the middle of a sweep, START held high through release.
    set_all(5000, 100, 200);
    enable = 1'b1; step_duty = W'(50); step_phase = W'(50);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);            // edge k
    repeat (49) @(posedge clk);
    #1;
    check("mid_busy_before", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    cnt = 0;
    for (int i = 0; i < D; i++) begin
      if (duty_s[i] != '0 || phase_s[i] != '0) cnt++;
    end
    check("mid_rst_nonzero", cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) cnt++;
    end
    check("mid_no_sweep_busy", cnt, 0);
    check("mid_duty_zero", int'(duty_s[0]), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
